// File: rtl/imem_boot_loader.sv
// Boot loader for the core's instruction memory: packs a byte stream little-endian
// into 32-bit words, writes them to consecutive addresses, then releases the core.
module imem_boot_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [15:0] load_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] pc_addr,
  output logic [31:0] imem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        cpu_run,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for a legal load_start, core held
  // LOAD  | accepting bytes, writing completed words
  // FLUSH | one-cycle write of the final word, stream closed
  // RUN   | imem address handed back to the PC, core released
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_nxt;
  logic [15:0] len_q;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] lanes_q;
  logic        start_req, len_bad, accept, word_done, last_word;

  assign start_req = load_start && ((state == IDLE) || (state == RUN));
  assign len_bad   = (load_words == 16'd0) || ({1'b0, load_words} > DEPTH_W);
  assign accept    = byte_valid && (state == LOAD);
  assign word_done = accept && (byte_cnt == 2'd3);
  // word_cnt has already caught up with the previous word's write by the time
  // the fourth byte of the next word can arrive
  assign last_word = (word_cnt == (len_q - 16'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN: if (start_req) state_nxt = len_bad ? IDLE : LOAD;
      LOAD:      if (word_done && last_word) state_nxt = FLUSH;
      FLUSH:     state_nxt = RUN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      len_q     <= 16'd0;
      word_cnt  <= 16'd0;
      byte_cnt  <= 2'd0;
      lanes_q   <= 24'd0;
      mem_we    <= 1'b0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= word_done;
      if (mem_we) word_cnt <= word_cnt + 16'd1;
      if (start_req) begin
        if (len_bad) begin
          err <= 1'b1;
        end else begin
          err      <= 1'b0;
          len_q    <= load_words;
          word_cnt <= 16'd0;
          byte_cnt <= 2'd0;
        end
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) mem_wdata <= {byte_data, lanes_q};
        else                  lanes_q[{byte_cnt, 3'b000} +: 8] <= byte_data;
      end
    end
  end

  assign byte_ready = (state == LOAD);
  assign busy       = (state == LOAD) || (state == FLUSH);
  assign cpu_run    = (state == RUN);
  assign imem_addr  = (state == RUN) ? pc_addr : {14'd0, word_cnt, 2'b00};

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a transaction-level model of the load
// sequence is compared against the DUT every cycle, plus literal spot checks.
module tb_imem_boot_loader;

  localparam int DEPTH = 256;
  localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_RUN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [15:0] load_words = 16'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic [31:0] pc_addr = 32'd0;
  logic [31:0] imem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        cpu_run;
  logic        err;

  imem_boot_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_words(load_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .pc_addr(pc_addr), .imem_addr(imem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .cpu_run(cpu_run), .err(err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: which phase the loader is in, how many whole words the
  // current load has produced, and a pending write from the last completed word
  int          m_mode = M_IDLE;
  bit          m_err = 1'b0;
  int          m_len = 0;
  int          m_done = 0;
  bit          m_we = 1'b0;
  logic [31:0] m_wdata = 32'd0;
  logic [7:0]  bq[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_err = 0; m_len = 0; m_done = 0; m_we = 0; m_wdata = 0;
      bq.delete();
    end else begin
      m_we = 0;
      case (m_mode)
        M_IDLE, M_RUN:
          if (load_start) begin
            if (load_words == 0 || int'(load_words) > DEPTH) begin
              m_err = 1; m_mode = M_IDLE;
            end else begin
              m_err = 0; m_len = int'(load_words); m_done = 0; bq.delete(); m_mode = M_LOAD;
            end
          end
        M_LOAD:
          if (byte_valid) begin
            bq.push_back(byte_data);
            if (bq.size() == 4) begin
              m_wdata = {bq[3], bq[2], bq[1], bq[0]};
              bq.delete();
              m_we = 1;
              m_done++;
              if (m_done == m_len) m_mode = M_FLUSH;
            end
          end
        default: m_mode = M_RUN;
      endcase
    end
  end

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  always @(negedge clk) begin
    logic [31:0] exp_addr;
    exp_addr = (m_mode == M_RUN) ? pc_addr : 32'(m_we ? 4 * (m_done - 1) : 4 * m_done);
    chk("byte_ready", byte_ready, m_mode == M_LOAD);
    chk("busy", busy, m_mode == M_LOAD || m_mode == M_FLUSH);
    chk("cpu_run", cpu_run, m_mode == M_RUN);
    chk("err", err, m_err);
    chk("mem_we", mem_we, m_we);
    chk("imem_addr", imem_addr, exp_addr);
    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    if (mem_we) begin
      log_a.push_back(imem_addr);
      log_d.push_back(mem_wdata);
    end
  end

  logic [7:0] prog[1024];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) prog[i] = 8'($urandom);
  endtask

  // stop_at > 0 abandons the stream after that many accepted bytes
  task automatic do_load(input int n, input int gap, input int stop_at, input bit poke,
                         output int cyc_cnt);
    int idx;
    bit acc;
    idx = 0;
    load_words = 16'(n);
    load_start = 1'b1;
    pc_addr = 32'h8;
    cyc();
    load_start = 1'b0;
    chk("ready_after_start", byte_ready, 1'b1);
    chk("run_dropped", cpu_run, 1'b0);
    chk("err_cleared", err, 1'b0);
    chk("load_addr_not_pc", imem_addr, 32'h0);
    cyc_cnt = 0;
    while (!cpu_run && cyc_cnt < 5000 && !(stop_at > 0 && idx >= stop_at)) begin
      byte_valid = ($urandom_range(99) >= gap);
      byte_data = (idx < 1024) ? prog[idx] : 8'($urandom);
      if (poke && cyc_cnt == 2) begin
        load_start = 1'b1;
        load_words = 16'd7;
      end
      acc = byte_valid && (m_mode == M_LOAD);
      cyc();
      load_start = 1'b0;
      if (acc) idx++;
      cyc_cnt++;
    end
    byte_valid = 1'b0;
    if (cyc_cnt >= 5000) begin
      checks++;
      errs++;
      $display("FAIL load_timeout: got no cpu_run after %0d cycles, required within 5000", cyc_cnt);
    end
  endtask

  task automatic check_log(input string nm, input int n);
    chk({nm, "_count"}, 32'(log_a.size()), 32'(n));
    for (int i = 0; i < n && i < log_a.size(); i++) begin
      chk({nm, "_addr"}, log_a[i], 32'(4 * i));
      chk({nm, "_data"}, log_d[i], {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]});
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      pc_addr = $urandom;
      byte_valid = $urandom_range(1);
      byte_data = 8'($urandom);
      cyc();
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    int nc;
    logic [7:0] t1[12];
    t1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h81, 8'h20, 8'h00, 8'hB3, 8'h01, 8'h31, 8'h00};
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_cpu_run", cpu_run, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // directed three-word program, continuous stream
    fill_random();
    for (int i = 0; i < 12; i++) prog[i] = t1[i];
    log_a.delete(); log_d.delete();
    do_load(3, 0, 0, 1'b0, nc);
    chk("t1_load_cycles", 32'(nc), 32'd13);
    chk("t1_count", 32'(log_a.size()), 32'd3);
    if (log_a.size() == 3) begin
      chk("t1_w0", log_d[0], 32'h00000013);
      chk("t1_w1", log_d[1], 32'h00208133);
      chk("t1_w2", log_d[2], 32'h003101B3);
      chk("t1_a2", log_a[2], 32'h8);
    end
    pc_addr = 32'h8;
    #1;
    chk("run_pc_addr", imem_addr, 32'h8);
    run_idle(5);

    // two words with random gaps and an ignored mid-load start
    fill_random();
    log_a.delete(); log_d.delete();
    do_load(2, 40, 0, 1'b1, nc);
    check_log("gap", 2);
    run_idle(3);

    // illegal lengths
    log_a.delete(); log_d.delete();
    foreach (t1[i]) begin end
    for (int k = 0; k < 2; k++) begin
      load_words = (k == 0) ? 16'd0 : 16'd257;
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      chk("bad_err", err, 1'b1);
      chk("bad_ready", byte_ready, 1'b0);
      chk("bad_run", cpu_run, 1'b0);
      run_idle(4);
    end
    chk("bad_no_write", 32'(log_a.size()), 32'd0);
    fill_random();
    do_load(1, 20, 0, 1'b0, nc);
    check_log("after_bad", 1);

    // reset in the middle of a three-word load
    fill_random();
    log_a.delete(); log_d.delete();
    do_load(3, 0, 6, 1'b0, nc);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", byte_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_we", mem_we, 1'b0);
    chk("mid_rst_wdata", mem_wdata, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    fill_random();
    log_a.delete(); log_d.delete();
    do_load(1, 30, 0, 1'b0, nc);
    check_log("post_rst", 1);

    // reload issued from RUN
    fill_random();
    log_a.delete(); log_d.delete();
    do_load(1, 0, 0, 1'b0, nc);
    check_log("reload", 1);
    chk("reload_run", cpu_run, 1'b1);

    // full-depth load
    fill_random();
    log_a.delete(); log_d.delete();
    do_load(DEPTH, 10, 0, 1'b0, nc);
    check_log("depth", DEPTH);
    run_idle(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
